// File: rtl/mem_fill_arbiter_pkg.sv
// wisc_mem_pkg: shared widths, block geometry and fill-arbiter state encoding
package wisc_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WPB = 8;
  localparam int MEM_LATENCY = 4;
  localparam int IDX_W = $clog2(WPB);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL_D = 2'd1, FILL_I = 2'd2} fill_state_e;
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:IDX_W+1], {(IDX_W+1){1'b0}}};
  endfunction
endpackage

// File: rtl/mem_fill_arbiter_if.sv
// mem_fill_arbiter_if: cache miss requests, memory read port, fill steering and stall lines
interface mem_fill_arbiter_if;
  import wisc_mem_pkg::*;
  logic icache_miss;
  logic [ADDR_W-1:0] icache_miss_addr;
  logic dcache_miss;
  logic [ADDR_W-1:0] dcache_miss_addr;
  logic mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_data_valid;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0] fill_word_idx;
  logic ifill_we;
  logic dfill_we;
  logic ifill_done;
  logic dfill_done;
  logic stall_if;
  logic stall_mem;
  modport master (
    input icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_data, fill_word_idx, ifill_we, dfill_we, ifill_done, dfill_done,
      stall_if, stall_mem
  );
  modport slave (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr, mem_data_valid, mem_data,
    input mem_en, mem_addr, fill_data, fill_word_idx, ifill_we, dfill_we, ifill_done, dfill_done,
      stall_if, stall_mem
  );
endinterface

// File: rtl/mem_fill_counter.sv
// mem_fill_counter: per-grant issue counter (saturating at WPB) and receive word counter
module mem_fill_counter
  import wisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             issue_inc,
  input  logic             recv_inc,
  output logic [IDX_W:0]   issue_cnt,
  output logic [IDX_W-1:0] recv_cnt,
  output logic             issue_full,
  output logic             recv_last
);
  assign issue_full = issue_cnt == (IDX_W+1)'(WPB);
  assign recv_last = recv_cnt == IDX_W'(WPB - 1);
  // Count issued reads and returned words; cleared whenever no fill is active
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      issue_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      if (issue_inc && !issue_full) issue_cnt <= issue_cnt + 1'b1;
      if (recv_inc) recv_cnt <= recv_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: grants I/D cache block fills on the shared memory, D side first
module mem_fill_arbiter
  import wisc_mem_pkg::*;
(
  input logic clk,
  input logic rst,
  mem_fill_arbiter_if.master bus
);
  fill_state_e state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W:0] issue_cnt;
  logic [IDX_W-1:0] recv_cnt;
  logic issue_full, recv_last, recv_fire, last_fire;
  mem_fill_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .issue_inc(bus.mem_en),
    .recv_inc(recv_fire),
    .issue_cnt(issue_cnt),
    .recv_cnt(recv_cnt),
    .issue_full(issue_full),
    .recv_last(recv_last)
  );
  assign recv_fire = bus.mem_data_valid && state != IDLE;
  assign last_fire = recv_fire && recv_last;
  assign bus.mem_en = state != IDLE && !issue_full;
  assign bus.mem_addr = bus.mem_en ? base + ADDR_W'({issue_cnt, 1'b0}) : '0;
  assign bus.fill_data = recv_fire ? bus.mem_data : '0;
  assign bus.fill_word_idx = recv_fire ? recv_cnt : '0;
  assign bus.ifill_we = recv_fire && state == FILL_I;
  assign bus.dfill_we = recv_fire && state == FILL_D;
  assign bus.ifill_done = last_fire && state == FILL_I;
  assign bus.dfill_done = last_fire && state == FILL_D;
  assign bus.stall_if = bus.icache_miss && !bus.ifill_done;
  assign bus.stall_mem = bus.dcache_miss && !bus.dfill_done;
  // Arbitrate in IDLE (D wins), latch the block base, return to IDLE after the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
    end else if (state == IDLE) begin
      if (bus.dcache_miss) begin
        state <= FILL_D;
        base <= block_base(bus.dcache_miss_addr);
      end else if (bus.icache_miss) begin
        state <= FILL_I;
        base <= block_base(bus.icache_miss_addr);
      end
    end else if (last_fire) state <= IDLE;
  end
endmodule
